// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and defaults for the memory port arbiter.
//   arb_state_e : arbiter FSM states (IDLE, REQ, WAIT, RESP)
//   arb_owner_e : which requester owns the current transaction (FETCH, DATA)
//   *_DEF       : default address/data widths and timeout length
//   cnt_width() : counter width able to hold 0..limit
// -----------------------------------------------------------------------------
package mem_arb_pkg;

   localparam int ADDR_W_DEF  = 32;
   localparam int DATA_W_DEF  = 32;
   localparam int TIMEOUT_DEF = 255;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } arb_state_e;

   typedef enum logic {
      FETCH = 1'b0,
      DATA  = 1'b1
   } arb_owner_e;

   function automatic int cnt_width(input int limit);
      return (limit < 2) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// -----------------------------------------------------------------------------
// mem_arb_timer
// Loadable up-counter that flags expiry once LIMIT cycles have been counted
// since the last clear. Counting stops at expiry so the flag cannot wrap away.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count at 0 (wins over enable)
//   enable     : advance the count by one this cycle
//   expired    : high once LIMIT cycles have elapsed since clear
// -----------------------------------------------------------------------------
module mem_arb_timer
   import mem_arb_pkg::*;
#(
   parameter int LIMIT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = cnt_width(LIMIT);
   // The cycle that completes the LIMIT-th count is the one that sees LIMIT-1,
   // so the owning FSM can leave on that same edge.
   localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

   logic [CW-1:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (enable && !expired) begin
         count_q <= count_q + CW'(1);
      end
   end

   assign expired = (count_q >= LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory bus port between instruction fetch (read-only) and the
// data stage (load/store). One transaction in flight, registered request and
// response paths, fixed data-over-fetch priority.
//
// Optional build macro: ARB_TIMEOUT_EN
//   defined   : a REQ+WAIT transaction lasting TIMEOUT_CYCLES is abandoned and
//               completed to its owner with Err=1 and Rdata=0.
//   undefined : no timer; I_Err/D_Err are constant 0; the FSM waits forever.
//
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   I_Req/I_Addr                : fetch request and address (held until I_Valid)
//   I_Rdata/I_Valid/I_Err       : fetch response, one-cycle pulse, abort flag
//   D_Req/D_We/D_Addr/D_Wdata/D_Be : data request (held until D_Valid)
//   D_Rdata/D_Valid/D_Err       : data response, one-cycle pulse, abort flag
//   Mem_Req/Mem_We/Mem_Addr/Mem_Wdata/Mem_Be : bus request, stable until Mem_Gnt
//   Mem_Gnt                     : bus accepts the request this cycle
//   Mem_Rvalid/Mem_Rdata        : bus response for reads and writes
// -----------------------------------------------------------------------------
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W         = ADDR_W_DEF,
   parameter int DATA_W         = DATA_W_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,

   input  logic                  I_Req,
   input  logic [ADDR_W-1:0]     I_Addr,
   output logic [DATA_W-1:0]     I_Rdata,
   output logic                  I_Valid,
   output logic                  I_Err,

   input  logic                  D_Req,
   input  logic                  D_We,
   input  logic [ADDR_W-1:0]     D_Addr,
   input  logic [DATA_W-1:0]     D_Wdata,
   input  logic [DATA_W/8-1:0]   D_Be,
   output logic [DATA_W-1:0]     D_Rdata,
   output logic                  D_Valid,
   output logic                  D_Err,

   output logic                  Mem_Req,
   output logic                  Mem_We,
   output logic [ADDR_W-1:0]     Mem_Addr,
   output logic [DATA_W-1:0]     Mem_Wdata,
   output logic [DATA_W/8-1:0]   Mem_Be,
   input  logic                  Mem_Gnt,
   input  logic                  Mem_Rvalid,
   input  logic [DATA_W-1:0]     Mem_Rdata
);

   localparam int BE_W = DATA_W / 8;
   localparam logic [BE_W-1:0] BE_ALL = '1;

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_REQ  = REQ;
   localparam logic [1:0] ST_WAIT = WAIT;
   localparam logic [1:0] ST_RESP = RESP;

   logic [1:0]        state_q, state_d;
   arb_owner_e        owner_q;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [DATA_W-1:0] wdata_q;
   logic [BE_W-1:0]   be_q;
   logic              mem_req_q;
   logic              i_valid_q, d_valid_q;
   logic [DATA_W-1:0] i_rdata_q, d_rdata_q;

   logic              start;
   logic              enter_resp;
   logic              expired;
   logic [DATA_W-1:0] rdata_next;

   assign start = (state_q == ST_IDLE) && (I_Req || D_Req);

   // ---------------------------------------------------------------------------
   // Optional transaction timeout
   // ---------------------------------------------------------------------------
`ifdef ARB_TIMEOUT_EN
   logic busy;
   logic timeout_hit;
   logic err_q;

   assign busy = (state_q == ST_REQ) || (state_q == ST_WAIT);

   mem_arb_timer #(
      .LIMIT   (TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (start),
      .enable  (busy),
      .expired (expired)
   );

   // A real grant or response arriving on the expiry cycle takes precedence.
   assign timeout_hit = expired &&
                        (((state_q == ST_REQ)  && !Mem_Gnt) ||
                         ((state_q == ST_WAIT) && !Mem_Rvalid));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= enter_resp && timeout_hit;
      end
   end

   assign I_Err = err_q && (owner_q == FETCH);
   assign D_Err = err_q && (owner_q == DATA);
`else
   assign expired = 1'b0;
   assign I_Err   = 1'b0;
   assign D_Err   = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // it unassigned; an unassigned path would infer a latch.
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (I_Req || D_Req)            state_d = ST_REQ;
         ST_REQ:  if (Mem_Gnt)                   state_d = ST_WAIT;
                  else if (expired)              state_d = ST_RESP;
         ST_WAIT: if (Mem_Rvalid || expired)     state_d = ST_RESP;
         ST_RESP:                                state_d = ST_IDLE;
         default:                                state_d = ST_IDLE;
      endcase
   end

   assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);

   // Only a genuine read response carries data; writes and aborts return 0.
   assign rdata_next = ((state_q == ST_WAIT) && Mem_Rvalid && !we_q) ? Mem_Rdata : '0;

   // ---------------------------------------------------------------------------
   // State, latched request fields and response registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         owner_q   <= FETCH;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         be_q      <= '0;
         mem_req_q <= 1'b0;
         i_valid_q <= 1'b0;
         d_valid_q <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         mem_req_q <= (state_d == ST_REQ);
         i_valid_q <= enter_resp && (owner_q == FETCH);
         d_valid_q <= enter_resp && (owner_q == DATA);

         if (start) begin
            if (D_Req) begin
               owner_q <= DATA;
               addr_q  <= D_Addr;
               we_q    <= D_We;
               wdata_q <= D_Wdata;
               be_q    <= D_We ? D_Be : BE_ALL;
            end else begin
               owner_q <= FETCH;
               addr_q  <= I_Addr;
               we_q    <= 1'b0;
               wdata_q <= '0;
               be_q    <= BE_ALL;
            end
         end

         // The non-owner's response register is left untouched.
         if (enter_resp) begin
            if (owner_q == FETCH) i_rdata_q <= rdata_next;
            else                  d_rdata_q <= rdata_next;
         end
      end
   end

   assign Mem_Req   = mem_req_q;
   assign Mem_We    = we_q;
   assign Mem_Addr  = addr_q;
   assign Mem_Wdata = wdata_q;
   assign Mem_Be    = be_q;

   assign I_Rdata   = i_rdata_q;
   assign I_Valid   = i_valid_q;
   assign D_Rdata   = d_rdata_q;
   assign D_Valid   = d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter. A behavioural memory behind the bus
// supplies read data and absorbs byte-enabled writes; requesters follow the
// hold-until-Valid handshake and the bench predicts owner, bus fields, latency
// and returned data from the arbitration rules.
// Build with ARB_TIMEOUT_EN to include the timeout scenario (TIMEOUT_CYCLES=8).
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;
   localparam int TO = 8;

   logic          clk;
   logic          rst_n;
   logic          I_Req;
   logic [AW-1:0] I_Addr;
   logic [DW-1:0] I_Rdata;
   logic          I_Valid;
   logic          I_Err;
   logic          D_Req;
   logic          D_We;
   logic [AW-1:0] D_Addr;
   logic [DW-1:0] D_Wdata;
   logic [BW-1:0] D_Be;
   logic [DW-1:0] D_Rdata;
   logic          D_Valid;
   logic          D_Err;
   logic          Mem_Req;
   logic          Mem_We;
   logic [AW-1:0] Mem_Addr;
   logic [DW-1:0] Mem_Wdata;
   logic [BW-1:0] Mem_Be;
   logic          Mem_Gnt;
   logic          Mem_Rvalid;
   logic [DW-1:0] Mem_Rdata;

   mem_port_arbiter #(
      .ADDR_W         (AW),
      .DATA_W         (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .I_Req      (I_Req),
      .I_Addr     (I_Addr),
      .I_Rdata    (I_Rdata),
      .I_Valid    (I_Valid),
      .I_Err      (I_Err),
      .D_Req      (D_Req),
      .D_We       (D_We),
      .D_Addr     (D_Addr),
      .D_Wdata    (D_Wdata),
      .D_Be       (D_Be),
      .D_Rdata    (D_Rdata),
      .D_Valid    (D_Valid),
      .D_Err      (D_Err),
      .Mem_Req    (Mem_Req),
      .Mem_We     (Mem_We),
      .Mem_Addr   (Mem_Addr),
      .Mem_Wdata  (Mem_Wdata),
      .Mem_Be     (Mem_Be),
      .Mem_Gnt    (Mem_Gnt),
      .Mem_Rvalid (Mem_Rvalid),
      .Mem_Rdata  (Mem_Rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_fail   = 0;
   int            cyc      = 0;
   int            last_valid_cyc;
   logic [DW-1:0] mem_model [logic [AW-1:0]];
   logic [DW-1:0] exp_i_rdata;
   logic [DW-1:0] exp_d_rdata;

   // Inputs are driven and outputs sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Untouched locations read back as an address-derived pattern.
   function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return a ^ 32'hA5C3_0F96;
   endfunction

   function automatic void mem_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                     input logic [BW-1:0] be);
      logic [DW-1:0] w;
      w = mem_read(a);
      for (int b = 0; b < BW; b++)
         if (be[b]) w[8*b +: 8] = d[8*b +: 8];
      mem_model[a] = w;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_mem_req"},   Mem_Req,   0);
      check({tag, "_mem_we"},    Mem_We,    0);
      check({tag, "_mem_addr"},  Mem_Addr,  0);
      check({tag, "_mem_wdata"}, Mem_Wdata, 0);
      check({tag, "_mem_be"},    Mem_Be,    0);
      check({tag, "_i_valid"},   I_Valid,   0);
      check({tag, "_i_err"},     I_Err,     0);
      check({tag, "_i_rdata"},   I_Rdata,   0);
      check({tag, "_d_valid"},   D_Valid,   0);
      check({tag, "_d_err"},     D_Err,     0);
      check({tag, "_d_rdata"},   D_Rdata,   0);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_i_valid"}, I_Valid, 0);
      check({tag, "_d_valid"}, D_Valid, 0);
      check({tag, "_i_rdata"}, I_Rdata, exp_i_rdata);
      check({tag, "_d_rdata"}, D_Rdata, exp_d_rdata);
   endtask

   // Called in an IDLE cycle with requests already presented. Plays the bus
   // with the given grant/response delays and returns in the RESP cycle with
   // the served requester's Req dropped. noisy drives stale Mem_Rvalid in REQ
   // (including the grant cycle) and in RESP.
   task automatic serve(input string tag, input int gnt_dly, input int rv_dly, input bit noisy);
      bit            own_d;
      logic [AW-1:0] ea;
      logic          ewe;
      logic [BW-1:0] ebe;
      logic [DW-1:0] ewd;
      logic [DW-1:0] resp;
      int            t0;
      own_d = D_Req;
      ea    = own_d ? D_Addr : I_Addr;
      ewe   = own_d && D_We;
      ebe   = ewe ? D_Be : {BW{1'b1}};
      ewd   = D_Wdata;
      resp  = ewe ? '0 : mem_read(ea);
      t0    = cyc;
      tick();
      for (int g = 0; g <= gnt_dly; g++) begin
         check({tag, "_req"},  Mem_Req,  1);
         check({tag, "_addr"}, Mem_Addr, ea);
         check({tag, "_we"},   Mem_We,   ewe);
         check({tag, "_be"},   Mem_Be,   ebe);
         if (ewe) check({tag, "_wdata"}, Mem_Wdata, ewd);
         check_quiet({tag, "_inreq"});
         Mem_Gnt    = (g == gnt_dly);
         Mem_Rvalid = noisy;
         Mem_Rdata  = $urandom;
         tick();
      end
      Mem_Gnt = 1'b0;
      for (int r = 0; r <= rv_dly; r++) begin
         check({tag, "_req_drop"}, Mem_Req, 0);
         check_quiet({tag, "_inwait"});
         Mem_Rvalid = (r == rv_dly);
         Mem_Rdata  = (r == rv_dly) ? resp : DW'($urandom);
         tick();
      end
      Mem_Rvalid = noisy;
      Mem_Rdata  = $urandom;
      if (own_d) exp_d_rdata = resp;
      else       exp_i_rdata = resp;
      last_valid_cyc = cyc;
      check({tag, "_latency"}, DW'(cyc - t0), DW'(3 + gnt_dly + rv_dly));
      check({tag, "_d_valid"}, D_Valid, own_d);
      check({tag, "_i_valid"}, I_Valid, !own_d);
      check({tag, "_d_rdata"}, D_Rdata, exp_d_rdata);
      check({tag, "_i_rdata"}, I_Rdata, exp_i_rdata);
      check({tag, "_d_err"},   D_Err,   0);
      check({tag, "_i_err"},   I_Err,   0);
      if (ewe) mem_write(ea, ewd, D_Be);
      if (own_d) D_Req = 1'b0;
      else       I_Req = 1'b0;
   endtask

   // Step from RESP into the following IDLE cycle.
   task automatic to_idle(input string tag);
      tick();
      Mem_Rvalid = 1'b0;
      check({tag, "_idle_req"}, Mem_Req, 0);
      check_quiet({tag, "_idle"});
   endtask

   initial begin
      int i_cyc;
      int d_cyc;
      rst_n = 1'b0; I_Req = 1'b0; I_Addr = '0;
      D_Req = 1'b0; D_We = 1'b0; D_Addr = '0; D_Wdata = '0; D_Be = '0;
      Mem_Gnt = 1'b0; Mem_Rvalid = 1'b0; Mem_Rdata = '0;
      exp_i_rdata = '0; exp_d_rdata = '0;
      last_valid_cyc = 0;

      // Reset state
      tick(); tick();
      check_all_zero("reset");
      rst_n = 1'b1;

      // Single load at 0x100, immediate grant, response next cycle
      mem_model[32'h100] = 32'hDEAD_BEEF;
      D_Req = 1'b1; D_We = 1'b0; D_Addr = 32'h100;
      serve("load", 0, 0, 1'b0);
      check("load_data", D_Rdata, 32'hDEAD_BEEF);
      to_idle("load");

      // Contention: data first, fetch on the next IDLE, 4 cycles later
      mem_model[32'h0] = 32'h0BAD_F00D;
      I_Req = 1'b1; I_Addr = 32'h0;
      D_Req = 1'b1; D_We = 1'b0; D_Addr = 32'h200;
      serve("cont_d", 0, 0, 1'b0);
      d_cyc = last_valid_cyc;
      check("cont_i_pending", I_Valid, 0);
      to_idle("cont_d");
      serve("cont_i", 0, 0, 1'b0);
      i_cyc = last_valid_cyc;
      check("cont_gap", DW'(i_cyc - d_cyc), 4);
      check("cont_i_data", I_Rdata, 32'h0BAD_F00D);
      to_idle("cont_i");

      // Store with grant held off for 3 cycles
      D_Req = 1'b1; D_We = 1'b1; D_Addr = 32'h100; D_Wdata = 32'h1234_5678; D_Be = 4'b0011;
      serve("store", 3, 0, 1'b0);
      check("store_rdata", D_Rdata, 0);
      to_idle("store");

      // Load back the merged word
      D_Req = 1'b1; D_We = 1'b0; D_Addr = 32'h100;
      serve("merge", 1, 2, 1'b0);
      check("merge_data", D_Rdata, 32'hDEAD_5678);
      to_idle("merge");

      // Spurious responses in IDLE, then in REQ (before and with the grant)
      for (int k = 0; k < 3; k++) begin
         Mem_Rvalid = 1'b1; Mem_Rdata = $urandom;
         tick();
         check("spur_idle_req", Mem_Req, 0);
         check_quiet("spur_idle");
      end
      Mem_Rvalid = 1'b0;
      I_Req = 1'b1; I_Addr = 32'h44;
      serve("spur_req", 2, 1, 1'b1);
      to_idle("spur_req");

      // Reset while in WAIT, then a late response after release
      D_Req = 1'b1; D_We = 1'b0; D_Addr = 32'h300;
      tick();
      check("rst_pre_req", Mem_Req, 1);
      Mem_Gnt = 1'b1;
      tick();
      Mem_Gnt = 1'b0;
      D_Req = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_all_zero("rst_async");
      tick();
      rst_n = 1'b1;
      exp_i_rdata = '0; exp_d_rdata = '0;
      Mem_Rvalid = 1'b1; Mem_Rdata = 32'hFFFF_FFFF;
      tick();
      check_all_zero("rst_late1");
      tick();
      Mem_Rvalid = 1'b0;
      check_all_zero("rst_late2");

`ifdef ARB_TIMEOUT_EN
      // Fetch never granted: abort exactly TO cycles after entering REQ
      begin
         int t0;
         I_Req = 1'b1; I_Addr = 32'h40;
         t0 = cyc;
         tick();
         for (int k = 0; k < TO; k++) begin
            check("to_req_held", Mem_Req, 1);
            check("to_no_valid", I_Valid, 0);
            tick();
         end
         check("to_cycle",   DW'(cyc - t0 - 1), TO);
         check("to_req_off", Mem_Req, 0);
         check("to_i_valid", I_Valid, 1);
         check("to_i_err",   I_Err,   1);
         check("to_i_rdata", I_Rdata, 0);
         check("to_d_valid", D_Valid, 0);
         check("to_d_err",   D_Err,   0);
         I_Req = 1'b0;
         exp_i_rdata = '0;
         Mem_Gnt = 1'b1; Mem_Rvalid = 1'b1; Mem_Rdata = 32'h5555_AAAA;
         tick();
         check("to_late_err", I_Err, 0);
         check_quiet("to_late1");
         tick();
         Mem_Gnt = 1'b0; Mem_Rvalid = 1'b0;
         check("to_late_req", Mem_Req, 0);
         check_quiet("to_late2");
      end
`endif

      // Randomised traffic: pending fetch stays presented until served
      for (int n = 0; n < 30; n++) begin
         if (!I_Req && ($urandom_range(0, 1) == 1)) begin
            I_Req  = 1'b1;
            I_Addr = 32'h1000 + (AW'($urandom_range(0, 7)) << 2);
         end
         if (!D_Req && ($urandom_range(0, 2) != 0)) begin
            D_Req   = 1'b1;
            D_We    = 1'($urandom_range(0, 1));
            D_Addr  = 32'h1000 + (AW'($urandom_range(0, 7)) << 2);
            D_Wdata = $urandom;
            D_Be    = BW'($urandom_range(1, 15));
         end
         if (!I_Req && !D_Req) begin
            I_Req  = 1'b1;
            I_Addr = 32'h1000;
         end
         serve("rand", $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
         to_idle("rand");
      end
      for (int n = 0; n < 2 && (I_Req || D_Req); n++) begin
         serve("drain", 0, 0, 1'b0);
         to_idle("drain");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
